factorial_slave: RTL and testbench

Bus slave that computes N! for a 32-bit operand written by a master. It sits downstream of the two-master/three-slave BUS and occupies one slave port (Sx_sel/S_address/S_wr/S_din in, Sx_dout back to the bus read mux). Masters program the operand, start the calculation, and poll status or wait for an optional interrupt. The 64-bit result is read back as two 32-bit words.

---
 rtl/factorial_slave_if.sv | 12 +
 rtl/factorial_slave.sv | 111 +++++++++++
 tb/tb_factorial_slave.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/factorial_slave_if.sv
// Bus port bundle for factorial_slave: select, direction, address, write data
// and the read data returned to the BUS read mux.
interface factorial_slave_if;
  logic        S_sel;
  logic        S_wr;
  logic [7:0]  S_address;
  logic [31:0] S_din;
  logic [31:0] S_dout;

  modport master (output S_sel, S_wr, S_address, S_din, input S_dout);
  modport slave  (input S_sel, S_wr, S_address, S_din, output S_dout);
endinterface

// File: rtl/factorial_slave.sv
// Bus slave computing a 64-bit N! (modulo 2^64) by iterated multiply.
// Optional level interrupt on completion is enabled by FACTORIAL_INTERRUPT_EN.
module factorial_slave (
  input  logic             clk,
  input  logic             reset_n,
  factorial_slave_if.slave bus
`ifdef FACTORIAL_INTERRUPT_EN
  ,
  output logic             interrupt
`endif
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [3:0] ADDR_OPCODE   = 4'h0;
  localparam logic [3:0] ADDR_CLEAR    = 4'h1;
  localparam logic [3:0] ADDR_INTR_EN  = 4'h2;
  localparam logic [3:0] ADDR_OPERAND  = 4'h3;
  localparam logic [3:0] ADDR_RESULT_H = 4'h4;
  localparam logic [3:0] ADDR_RESULT_L = 4'h5;
  localparam logic [3:0] ADDR_STATUS   = 4'h6;

  state_t      state;
  logic [31:0] operand;
  logic [31:0] count;
  logic [63:0] result;
`ifdef FACTORIAL_INTERRUPT_EN
  logic        intr_en;
`endif

  logic       wr_en;
  logic       rd_en;
  logic [3:0] addr;
  logic       start;
  logic       clear;
  logic       unused_addr;

  assign addr        = bus.S_address[3:0];
  assign unused_addr = ^bus.S_address[7:4];
  assign wr_en       = bus.S_sel & bus.S_wr;
  assign rd_en       = bus.S_sel & ~bus.S_wr;
  assign start       = wr_en && (addr == ADDR_OPCODE) && bus.S_din[0];
  assign clear       = wr_en && (addr == ADDR_CLEAR)  && bus.S_din[0];

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      operand <= '0;
      count   <= '0;
      result  <= '0;
`ifdef FACTORIAL_INTERRUPT_EN
      intr_en   <= 1'b0;
      interrupt <= 1'b0;
`endif
    end else begin
      if (wr_en && addr == ADDR_OPERAND)
        operand <= bus.S_din;
`ifdef FACTORIAL_INTERRUPT_EN
      if (wr_en && addr == ADDR_INTR_EN)
        intr_en <= bus.S_din[0];
      interrupt <= (state == DONE) && intr_en;
`endif

      if (clear) begin
        state  <= IDLE;
        result <= '0;
        count  <= '0;
      end else begin
        unique case (state)
          IDLE, DONE: begin
            if (start) begin
              state  <= CALC;
              count  <= operand;
              result <= 64'd1;
            end
          end
          CALC: begin
            // Start requests are ignored here; the count was snapshotted at start.
            if (count <= 32'd1) begin
              state <= DONE;
            end else begin
              result <= result * 64'(count);
              count  <= count - 32'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // NOTE: S_dout gets a default first so no path through the mux infers a latch.
  always_comb begin
    bus.S_dout = 32'h0;
    if (rd_en) begin
      unique case (addr)
`ifdef FACTORIAL_INTERRUPT_EN
        ADDR_INTR_EN:  bus.S_dout = {31'h0, intr_en};
`endif
        ADDR_OPERAND:  bus.S_dout = operand;
        ADDR_RESULT_H: bus.S_dout = result[63:32];
        ADDR_RESULT_L: bus.S_dout = result[31:0];
        ADDR_STATUS:   bus.S_dout = {30'h0, state == CALC, state == DONE};
        default:       bus.S_dout = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_factorial_slave.sv
// Directed self-checking bench for factorial_slave: table of N! vectors plus
// hand-written sequences for restart, clear, async reset and interrupt.
module tb_factorial_slave;

  localparam logic [3:0] A_OPCODE   = 4'h0;
  localparam logic [3:0] A_CLEAR    = 4'h1;
  localparam logic [3:0] A_INTR_EN  = 4'h2;
  localparam logic [3:0] A_OPERAND  = 4'h3;
  localparam logic [3:0] A_RESULT_H = 4'h4;
  localparam logic [3:0] A_RESULT_L = 4'h5;
  localparam logic [3:0] A_STATUS   = 4'h6;

  typedef struct {
    logic [31:0] n;
    logic [63:0] fact;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n;
`ifdef FACTORIAL_INTERRUPT_EN
  logic interrupt;
`endif

  factorial_slave_if bus ();

  factorial_slave dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus.slave)
`ifdef FACTORIAL_INTERRUPT_EN
    ,
    .interrupt(interrupt)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.S_sel     = 1'b1;
    bus.S_wr      = 1'b1;
    bus.S_address = {4'h0, a};
    bus.S_din     = d;
    @(posedge clk);
    #1;
    bus.S_sel = 1'b0;
    bus.S_wr  = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    bus.S_sel     = 1'b1;
    bus.S_wr      = 1'b0;
    bus.S_address = {4'h0, a};
    #1;
    d = bus.S_dout;
    bus.S_sel = 1'b0;
  endtask

  vec_t        vecs[7];
  logic [31:0] d;
  logic [31:0] hi;
  logic [31:0] lo;

  initial begin
    vecs[0] = '{n: 32'd5,  fact: 64'h78};
    vecs[1] = '{n: 32'd0,  fact: 64'h1};
    vecs[2] = '{n: 32'd1,  fact: 64'h1};
    vecs[3] = '{n: 32'd3,  fact: 64'h6};
    vecs[4] = '{n: 32'd12, fact: 64'h1C8C_FC00};
    vecs[5] = '{n: 32'd13, fact: 64'h1_7328_CC00};
    vecs[6] = '{n: 32'd20, fact: 64'h21C3_677C_82B4_0000};

    bus.S_sel     = 1'b0;
    bus.S_wr      = 1'b0;
    bus.S_address = 8'h0;
    bus.S_din     = 32'h0;

    // Reset state
    reset_n = 1'b0;
    #17;
    reset_n = 1'b1;
    for (int a = 0; a <= 6; a++) begin
      bus_read(4'(a), d);
      check($sformatf("reset_reg_%0d", a), 64'(d), 64'h0);
    end
    bus_read(4'hF, d);
    check("unmapped_0xF", 64'(d), 64'h0);
`ifdef FACTORIAL_INTERRUPT_EN
    check("reset_interrupt", 64'(interrupt), 64'h0);
`endif

    // Table-driven factorials; later entries restart from DONE
    for (int i = 0; i < 7; i++) begin
      int   lat;
      logic busy_ok;
      lat     = (vecs[i].n == 0) ? 1 : int'(vecs[i].n);
      busy_ok = 1'b1;
      bus_write(A_OPERAND, vecs[i].n);
      bus_write(A_OPCODE, 32'h1);
      for (int k = 0; k < lat; k++) begin
        if (k > 0) begin
          @(posedge clk);
          #1;
        end
        bus_read(A_STATUS, d);
        if (d !== 32'h2) busy_ok = 1'b0;
      end
      check($sformatf("busy_window_n%0d", vecs[i].n), 64'(busy_ok), 64'h1);
      @(posedge clk);
      #1;
      bus_read(A_STATUS, d);
      check($sformatf("status_done_n%0d", vecs[i].n), 64'(d), 64'h1);
      bus_read(A_RESULT_H, hi);
      bus_read(A_RESULT_L, lo);
      check($sformatf("result_n%0d", vecs[i].n), {hi, lo}, vecs[i].fact);
    end

    // Read-only registers ignore writes; deselected bus reads 0
    bus_write(A_RESULT_L, 32'hDEAD_BEEF);
    bus_write(A_STATUS, 32'h0);
    bus_read(A_RESULT_L, d);
    check("result_l_readonly", 64'(d), 64'h82B4_0000);
    bus_read(A_STATUS, d);
    check("status_readonly", 64'(d), 64'h1);
    bus.S_address = {4'h0, A_STATUS};
    #1;
    check("dout_deselected", 64'(bus.S_dout), 64'h0);

    // Start and OPERAND write during CALC are ignored by the running job
    begin
      logic done_seen;
      done_seen = 1'b0;
      bus_write(A_OPERAND, 32'd10);
      bus_write(A_OPCODE, 32'h1);
      repeat (2) @(posedge clk);
      bus_write(A_OPCODE, 32'h1);
      bus_write(A_OPERAND, 32'd3);
      for (int k = 0; k < 50 && !done_seen; k++) begin
        @(posedge clk);
        #1;
        bus_read(A_STATUS, d);
        if (d == 32'h1) done_seen = 1'b1;
      end
      check("n10_done_reached", 64'(done_seen), 64'h1);
      bus_read(A_RESULT_L, d);
      check("n10_result_l", 64'(d), 64'h37_5F00);
      bus_read(A_RESULT_H, d);
      check("n10_result_h", 64'(d), 64'h0);
      bus_read(A_OPERAND, d);
      check("operand_updated", 64'(d), 64'h3);
    end

    // Clear at cycle 4 of N=12, after checking the partial product
    bus_write(A_OPERAND, 32'd12);
    bus_write(A_OPCODE, 32'h1);
    repeat (3) @(posedge clk);
    #1;
    bus_read(A_RESULT_L, d);
    check("n12_partial", 64'(d), 64'd1320);
    bus_write(A_CLEAR, 32'h1);
    bus_read(A_STATUS, d);
    check("clear_status", 64'(d), 64'h0);
    bus_read(A_RESULT_H, hi);
    bus_read(A_RESULT_L, lo);
    check("clear_result", {hi, lo}, 64'h0);

    // Interrupt enable register
`ifdef FACTORIAL_INTERRUPT_EN
    bus_write(A_INTR_EN, 32'h1);
    bus_read(A_INTR_EN, d);
    check("intr_en_readback", 64'(d), 64'h1);
    bus_write(A_OPERAND, 32'd20);
    bus_write(A_OPCODE, 32'h1);
    repeat (19) @(posedge clk);
    @(posedge clk);
    #1;
    bus_read(A_STATUS, d);
    check("irq_status_done", 64'(d), 64'h1);
    check("irq_low_at_done", 64'(interrupt), 64'h0);
    @(posedge clk);
    #1;
    check("irq_high_after_done", 64'(interrupt), 64'h1);
    bus_write(A_CLEAR, 32'h1);
    check("irq_held_at_clear", 64'(interrupt), 64'h1);
    @(posedge clk);
    #1;
    check("irq_low_after_clear", 64'(interrupt), 64'h0);
`else
    bus_write(A_INTR_EN, 32'h1);
    bus_read(A_INTR_EN, d);
    check("intr_en_absent", 64'(d), 64'h0);
`endif

    // Asynchronous reset in the middle of CALC
    bus_write(A_OPERAND, 32'd12);
    bus_write(A_OPCODE, 32'h1);
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    bus_read(A_STATUS, d);
    check("async_reset_status", 64'(d), 64'h0);
    bus_read(A_RESULT_L, d);
    check("async_reset_result_l", 64'(d), 64'h0);
    bus_read(A_OPERAND, d);
    check("async_reset_operand", 64'(d), 64'h0);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    bus_read(A_STATUS, d);
    check("post_reset_idle", 64'(d), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
